// File: rtl/nco_ctrl_pkg.sv
// Shared state encoding and width defaults for the NCO sweep controller.
package nco_ctrl_pkg;

    localparam int unsigned PHI_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_DWELL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/nco_sweep_ctrl.sv
// Steps the NCO phase increment through a programmed sweep, gating clken and
// flagging settled samples once the NCO pipeline has flushed after each hop.
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int unsigned PHI_W     = PHI_W_DEF,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned PRIME_TMO = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [PHI_W-1:0] cfg_phi0_i,
    input  logic [PHI_W-1:0] cfg_step_i,
    input  logic [CNT_W-1:0] cfg_nsteps_i,
    input  logic [CNT_W-1:0] cfg_dwell_i,
    input  logic             nco_valid_i,
    output logic [PHI_W-1:0] phi_inc_o,
    output logic             nco_clken_o,
    output logic [CNT_W-1:0] step_idx_o,
    output logic             seg_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int unsigned TMO_W = (PRIME_TMO < 2) ? 1 : $clog2(PRIME_TMO);
    localparam int unsigned SET_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    state_t           state, state_n;
    logic [PHI_W-1:0] step_q, phi_n;
    logic [CNT_W-1:0] nsteps_q, dwell_last_q, dwell_cnt, dwell_n, idx_n;
    logic [TMO_W-1:0] prime_cnt, prime_n;
    logic [SET_W-1:0] settle_cnt, settle_n;
    logic             load_cfg, err_n, done_n, seg_n, clken_n, busy_n;

    always_comb begin
        state_n  = state;
        phi_n    = phi_inc_o;
        idx_n    = step_idx_o;
        dwell_n  = dwell_cnt;
        settle_n = (settle_cnt != '0) ? settle_cnt - SET_W'(1) : settle_cnt;
        prime_n  = prime_cnt;
        err_n    = err_o;
        done_n   = 1'b0;
        seg_n    = 1'b0;
        load_cfg = 1'b0;

        if (abort_i) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        load_cfg = 1'b1;
                        err_n    = 1'b0;
                        if (cfg_nsteps_i == '0) begin
                            done_n = 1'b1;
                        end else begin
                            phi_n   = cfg_phi0_i;
                            idx_n   = '0;
                            prime_n = '0;
                            state_n = ST_PRIME;
                        end
                    end
                end
                ST_PRIME: begin
                    if (nco_valid_i) begin
                        dwell_n  = '0;
                        settle_n = '0;
                        state_n  = ST_DWELL;
                    end else if (prime_cnt == TMO_W'(PRIME_TMO - 1)) begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        prime_n = prime_cnt + TMO_W'(1);
                    end
                end
                ST_DWELL: begin
                    seg_n = nco_valid_i && (settle_cnt == '0);
                    // Dwell counts free-running cycles, independent of nco_valid_i.
                    if (dwell_cnt == dwell_last_q) begin
                        if (step_idx_o == nsteps_q - CNT_W'(1)) begin
                            state_n = ST_DONE;
                        end else begin
                            phi_n    = phi_inc_o + step_q;
                            idx_n    = step_idx_o + CNT_W'(1);
                            dwell_n  = '0;
                            settle_n = SET_W'(SETTLE);
                        end
                    end else begin
                        dwell_n = dwell_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: state_n = ST_IDLE;
                default: state_n = ST_IDLE;
            endcase
        end

        clken_n = (state_n != ST_IDLE);
        busy_n  = (state_n == ST_PRIME) || (state_n == ST_DWELL);
        if (state_n == ST_DONE) begin
            done_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            phi_inc_o    <= '0;
            step_idx_o   <= '0;
            nco_clken_o  <= 1'b0;
            seg_valid_o  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            step_q       <= '0;
            nsteps_q     <= '0;
            dwell_last_q <= '0;
            dwell_cnt    <= '0;
            prime_cnt    <= '0;
            settle_cnt   <= '0;
        end else begin
            state       <= state_n;
            phi_inc_o   <= phi_n;
            step_idx_o  <= idx_n;
            nco_clken_o <= clken_n;
            seg_valid_o <= seg_n;
            busy_o      <= busy_n;
            done_o      <= done_n;
            err_o       <= err_n;
            dwell_cnt   <= dwell_n;
            prime_cnt   <= prime_n;
            settle_cnt  <= settle_n;
            if (load_cfg) begin
                step_q       <= cfg_step_i;
                nsteps_q     <= cfg_nsteps_i;
                dwell_last_q <= (cfg_dwell_i == '0) ? '0 : cfg_dwell_i - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Randomized bench for nco_sweep_ctrl against a closed-form timeline model.
module tb_nco_sweep_ctrl;

    logic        clk, reset, start_i, abort_i, nco_valid_i;
    logic [31:0] cfg_phi0_i, cfg_step_i;
    logic [15:0] cfg_nsteps_i, cfg_dwell_i;
    logic [31:0] phi_inc_o;
    logic [15:0] step_idx_o;
    logic        nco_clken_o, seg_valid_o, busy_o, done_o, err_o;

    typedef struct packed {
        logic [31:0] phi;
        logic        clken;
        logic [15:0] idx;
        logic        seg;
        logic        busy;
        logic        done;
        logic        err;
    } obs_t;

    int tests = 0;
    int fails = 0;

    // Model state carried between sweeps (what the outputs hold while idle).
    logic [31:0] m_phi;
    logic [15:0] m_idx;
    logic        m_err;

    nco_sweep_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .cfg_phi0_i   (cfg_phi0_i),
        .cfg_step_i   (cfg_step_i),
        .cfg_nsteps_i (cfg_nsteps_i),
        .cfg_dwell_i  (cfg_dwell_i),
        .nco_valid_i  (nco_valid_i),
        .phi_inc_o    (phi_inc_o),
        .nco_clken_o  (nco_clken_o),
        .step_idx_o   (step_idx_o),
        .seg_valid_o  (seg_valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample_outputs();
        obs_t o;
        o.phi   = phi_inc_o;
        o.clken = nco_clken_o;
        o.idx   = step_idx_o;
        o.seg   = seg_valid_o;
        o.busy  = busy_o;
        o.done  = done_o;
        o.err   = err_o;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Point i occupies output cycles [e+i*d, e+(i+1)*d) after the start edge, where
    // e is the first DWELL cycle (one after valid first seen) and d = max(dwell,1).
    task automatic run_sweep(input string name, input logic [31:0] phi0, input logic [31:0] step,
                             input int n, input int dwell, input int vfirst,
                             input bit drop, input bit collide);
        bit   vld [0:255];
        int   d, e, kend, i, j, off;
        bit   tmo;
        obs_t exp_o, got;
        d    = (dwell == 0) ? 1 : dwell;
        e    = vfirst + 1;
        tmo  = (n > 0) && (vfirst >= 65);
        kend = (n == 0) ? 3 : (tmo ? 67 : e + n * d + 2);
        for (int k = 0; k < 256; k++)
            vld[k] = (k == vfirst) || ((k > vfirst) && (!drop || $urandom_range(3) != 0));

        cfg_phi0_i   = phi0;
        cfg_step_i   = step;
        cfg_nsteps_i = 16'(n);
        cfg_dwell_i  = 16'(dwell);
        start_i      = 1'b1;
        nco_valid_i  = 1'b0;
        tick();
        start_i      = 1'b0;
        cfg_phi0_i   = $urandom;
        cfg_step_i   = $urandom;
        cfg_nsteps_i = 16'($urandom);
        cfg_dwell_i  = 16'($urandom);
        m_err        = 1'b0;

        for (int k = 1; k <= kend; k++) begin
            exp_o     = '0;
            exp_o.phi = m_phi;
            exp_o.idx = m_idx;
            if (n == 0) begin
                exp_o.done = (k == 1);
            end else if (tmo) begin
                exp_o.phi   = phi0;
                exp_o.idx   = '0;
                exp_o.clken = (k <= 64);
                exp_o.busy  = (k <= 64);
                exp_o.err   = (k > 64);
            end else begin
                i = (k < e) ? 0 : (k - e) / d;
                if (i > n - 1) i = n - 1;
                exp_o.phi   = phi0 + step * 32'(i);
                exp_o.idx   = 16'(i);
                exp_o.clken = (k <= e + n * d);
                exp_o.busy  = (k < e + n * d);
                exp_o.done  = (k == e + n * d);
                j = k - 1;
                if (j >= e && j < e + n * d && vld[j]) begin
                    off = j - e;
                    exp_o.seg = (off < d) || ((off % d) >= 4);
                end
            end
            got = sample_outputs();
            tests++;
            if (got !== exp_o) begin
                fails++;
                $display("FAIL %s k=%0d got phi=%h clken=%b idx=%0d seg=%b busy=%b done=%b err=%b want phi=%h clken=%b idx=%0d seg=%b busy=%b done=%b err=%b",
                         name, k, got.phi, got.clken, got.idx, got.seg, got.busy, got.done, got.err,
                         exp_o.phi, exp_o.clken, exp_o.idx, exp_o.seg, exp_o.busy, exp_o.done, exp_o.err);
            end
            if (collide && k == 3 && exp_o.busy) begin
                start_i      = 1'b1;
                cfg_nsteps_i = 16'($urandom_range(1, 9));
            end
            nco_valid_i = vld[k];
            tick();
            start_i = 1'b0;
        end

        if (tmo) begin
            m_phi = phi0;
            m_idx = '0;
            m_err = 1'b1;
        end else if (n > 0) begin
            m_phi = phi0 + step * 32'(n - 1);
            m_idx = 16'(n - 1);
        end
        nco_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got;
        repeat (2) tick();
        got = sample_outputs();
        tests++;
        if (got !== '0) begin
            fails++;
            $display("FAIL reset_state got %h want 0", got);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        run_sweep("basic", 32'h06666666, 32'h00100000, 3, 10, 8, 1'b0, 1'b0);
        tests++;
        if (phi_inc_o !== 32'h06866666) begin
            fails++;
            $display("FAIL basic_last_phi got %h want 06866666", phi_inc_o);
        end
    endtask

    task automatic test_wrap();
        run_sweep("wrap", 32'hFFFFFFF0, 32'h00000020, 2, 3, 2, 1'b0, 1'b0);
        tests++;
        if (phi_inc_o !== 32'h00000010 || err_o !== 1'b0) begin
            fails++;
            $display("FAIL wrap_phi got %h err=%b want 00000010 err=0", phi_inc_o, err_o);
        end
    endtask

    task automatic test_edge_cfg();
        run_sweep("nsteps0", $urandom, $urandom, 0, 5, 3, 1'b0, 1'b0);
        run_sweep("dwell0", $urandom, $urandom, 2, 0, 3, 1'b1, 1'b0);
    endtask

    task automatic test_prime_timeout();
        run_sweep("timeout", $urandom, $urandom, 2, 5, 70, 1'b0, 1'b0);
        tests++;
        if (err_o !== 1'b1 || done_o !== 1'b0) begin
            fails++;
            $display("FAIL timeout_sticky got err=%b done=%b want err=1 done=0", err_o, done_o);
        end
        run_sweep("err_clear", $urandom, $urandom, 2, 4, 2, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++)
            run_sweep("random", $urandom, $urandom, $urandom_range(1, 4), $urandom_range(0, 7),
                      $urandom_range(1, 10), 1'b1, 1'($urandom_range(1)));
        run_sweep("busy_start", $urandom, $urandom, 3, 5, 2, 1'b0, 1'b1);
    endtask

    task automatic test_abort();
        logic [31:0] phi0, step;
        int          c;
        phi0         = $urandom;
        step         = $urandom;
        cfg_phi0_i   = phi0;
        cfg_step_i   = step;
        cfg_nsteps_i = 16'd4;
        cfg_dwell_i  = 16'd6;
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
        nco_valid_i  = 1'b1;
        c = 0;
        while (step_idx_o !== 16'd1 && c < 40) begin
            tick();
            c++;
        end
        tests++;
        if (step_idx_o !== 16'd1) begin
            fails++;
            $display("FAIL abort_reach_step1 got idx=%0d want 1 within 40 cycles", step_idx_o);
        end
        tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        tests++;
        if ({nco_clken_o, busy_o, seg_valid_o, done_o} !== 4'b0000 || step_idx_o !== 16'd1 ||
            phi_inc_o !== phi0 + step) begin
            fails++;
            $display("FAIL abort_idle got clken=%b busy=%b seg=%b done=%b idx=%0d phi=%h want 0 0 0 0 1 %h",
                     nco_clken_o, busy_o, seg_valid_o, done_o, step_idx_o, phi_inc_o, phi0 + step);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (done_o !== 1'b0 || nco_clken_o !== 1'b0) begin
                fails++;
                $display("FAIL abort_no_done k=%0d got done=%b clken=%b want 0 0", k, done_o, nco_clken_o);
            end
        end
        nco_valid_i = 1'b0;
        m_phi = phi0 + step;
        m_idx = 16'd1;
    endtask

    task automatic test_collision();
        cfg_phi0_i   = $urandom;
        cfg_nsteps_i = 16'd2;
        start_i      = 1'b1;
        abort_i      = 1'b1;
        tick();
        start_i      = 1'b0;
        abort_i      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if ({busy_o, nco_clken_o, done_o} !== 3'b000 || phi_inc_o !== m_phi) begin
                fails++;
                $display("FAIL start_abort_same_cycle k=%0d got busy=%b clken=%b done=%b phi=%h want 0 0 0 %h",
                         k, busy_o, nco_clken_o, done_o, phi_inc_o, m_phi);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        obs_t got;
        cfg_phi0_i   = $urandom;
        cfg_step_i   = $urandom;
        cfg_nsteps_i = 16'd3;
        cfg_dwell_i  = 16'd8;
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
        nco_valid_i  = 1'b1;
        repeat (5) tick();
        #3;
        reset = 1'b1;
        #1;
        got = sample_outputs();
        tests++;
        if (got !== '0) begin
            fails++;
            $display("FAIL async_reset got %h want 0", got);
        end
        nco_valid_i = 1'b0;
        tick();
        reset = 1'b0;
        m_phi = '0;
        m_idx = '0;
        m_err = 1'b0;
        tick();
        run_sweep("after_reset", $urandom, $urandom, 3, 4, 3, 1'b1, 1'b0);
    endtask

    initial begin
        clk          = 1'b0;
        reset        = 1'b1;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        nco_valid_i  = 1'b0;
        cfg_phi0_i   = '0;
        cfg_step_i   = '0;
        cfg_nsteps_i = '0;
        cfg_dwell_i  = '0;
        m_phi        = '0;
        m_idx        = '0;
        m_err        = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_edge_cfg();
        test_prime_timeout();
        test_random();
        test_abort();
        test_collision();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
